// File: rtl/inst_fetch_unit.sv
`default_nettype none
// inst_fetch_unit: owns the PC and sequences IDLE/FETCH/EXEC/HALT against a 1-cycle instruction ROM.
// Rev 1.0 - run, single-step and halt control for the debug view.
module inst_fetch_unit #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [3:0]      HALT_OP  = 4'hF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run_en,
  input  logic            step,
  input  logic            jump,
  input  logic            jump_taken,
  input  logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     inst,
  output logic            inst_valid,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic [15:0]     inst_q, inst_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      inst_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    case (state_q)
      S_IDLE: begin
        if (run_en || step) state_d = S_FETCH;
      end
      S_FETCH: begin
        inst_d  = imem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (inst_q[15:12] == HALT_OP) begin
          state_d = S_HALT;
        end else begin
          // Sequential increment wraps naturally at 2^PC_W.
          pc_d    = (jump && jump_taken) ? jump_target : pc_q + 1'b1;
          addr_d  = pc_d;
          state_d = run_en ? S_FETCH : S_IDLE;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Decoded straight from the state flop so reset drops the commit strobe without waiting for a clock.
  assign inst_valid = (state_q == S_EXEC);
  assign halted     = (state_q == S_HALT);
  assign inst       = inst_q;
  assign pc         = pc_q;
  assign imem_addr  = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// Scoreboard bench for inst_fetch_unit: random ROM and jump stimulus, executed-instruction model, decoupled monitor.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_en = 1'b0;
  logic        step = 1'b0;
  logic        jump, jump_taken;
  logic [7:0]  jump_target;
  logic [7:0]  imem_addr, pc;
  logic [15:0] imem_rdata, inst;
  logic        inst_valid, halted;

  logic [15:0] rom [0:255];
  logic        jk  [0:255];
  logic        tk  [0:255];
  logic [7:0]  gk  [0:255];
  logic [7:0]  exec_cnt;

  typedef struct packed {logic [7:0] epc; logic [15:0] einst;} exp_t;
  exp_t expq[$];

  int checks = 0, errors = 0;
  int cyc = 0, last_v = -1, nvalid = 0;
  bit gap_chk = 1'b0;

  inst_fetch_unit #(.PC_W(8), .HALT_OP(4'hF), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .step(step),
    .jump(jump), .jump_taken(jump_taken), .jump_target(jump_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst(inst), .inst_valid(inst_valid), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  // The address is a register, so the word it selects is the data available in the following cycle.
  assign imem_rdata = rom[imem_addr];

  // Jump inputs are chosen per executed instruction, indexed by how many have completed.
  assign jump        = jk[exec_cnt];
  assign jump_taken  = tk[exec_cnt];
  assign jump_target = gk[exec_cnt];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exec_cnt <= 8'd0;
    else if (inst_valid) exec_cnt <= exec_cnt + 8'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected instruction stream: start at the reset PC, stop after a halt opcode,
  // otherwise follow a taken jump or step by one (8-bit wrap).
  function automatic void build(input int n);
    logic [7:0] p;
    exp_t e;
    p = 8'h00;
    for (int k = 0; k < n; k++) begin
      e.epc = p;
      e.einst = rom[p];
      expq.push_back(e);
      if (rom[p][15:12] == 4'hF) break;
      if (jk[k] && tk[k]) p = gk[k];
      else p = p + 8'd1;
    end
  endfunction

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'($urandom);
      if (rom[i][15:12] == 4'hF) rom[i][15:12] = 4'hE;
      jk[i] = 1'b0;
      tk[i] = 1'b0;
      gk[i] = 8'($urandom);
    end
  endtask

  task automatic wait_execs(input int n, input int budget, input string name);
    int t;
    t = 0;
    while (nvalid < n && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    check(name, nvalid, n);
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n && inst_valid) begin
      nvalid++;
      if (gap_chk && last_v >= 0) check("run_gap", cyc - last_v, 2);
      last_v = cyc;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_exec: got pc %0h expected no execute", pc);
      end else begin
        e = expq.pop_front();
        check("exec_pc", pc, e.epc);
        check("exec_inst", inst, e.einst);
        check("imem_addr_eq_pc", imem_addr, pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    fill_rom();
    #1;
    check("rst_pc", pc, 8'h00);
    check("rst_addr", imem_addr, 8'h00);
    check("rst_inst", inst, 16'h0000);
    check("rst_valid", inst_valid, 1'b0);
    check("rst_halted", halted, 1'b0);

    // Free run with directed jumps (taken, not taken, to 0xFF for wrap) then random jumps.
    rom[0] = 16'h1000; rom[1] = 16'h5001; rom[2] = 16'h2005; rom[3] = 16'h7003;
    for (int k = 0; k < 256; k++) begin
      jk[k] = ($urandom_range(0, 3) == 0);
      tk[k] = 1'($urandom_range(0, 1));
      gk[k] = 8'($urandom);
    end
    jk[0] = 1'b0; jk[1] = 1'b0;
    jk[2] = 1'b1; tk[2] = 1'b1; gk[2] = 8'h05;
    jk[3] = 1'b1; tk[3] = 1'b0;
    jk[4] = 1'b1; tk[4] = 1'b1; gk[4] = 8'hFF;
    jk[5] = 1'b0; jk[6] = 1'b0;
    expq.delete();
    build(60);
    run_en = 1'b1;
    gap_chk = 1'b1;
    last_v = -1;
    nvalid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_execs(60, 400, "run_exec_count");
    rst_n = 1'b0;
    gap_chk = 1'b0;
    check("run_drain", expq.size(), 0);

    // Halt opcode at pc 4; step and run_en must have no effect afterwards.
    fill_rom();
    rom[4] = 16'hF000;
    expq.delete();
    build(10);
    nvalid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_execs(5, 100, "halt_exec_count");
    @(negedge clk);
    #1;
    check("halt_flag", halted, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step = i[0];
      run_en = 1'($urandom_range(0, 1));
      @(negedge clk);
      #1;
      check("halt_valid", inst_valid, 1'b0);
      check("halt_pc", pc, 8'h04);
    end
    step = 1'b0;
    check("halt_inst_held", inst, 16'hF000);
    rst_n = 1'b0;
    #1;
    check("halt_rst_pc", pc, 8'h00);
    check("halt_rst_halted", halted, 1'b0);
    check("halt_drain", expq.size(), 0);

    // Single-step: three isolated pulses, one instruction each.
    fill_rom();
    run_en = 1'b0;
    expq.delete();
    build(3);
    nvalid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      repeat (10) @(negedge clk);
      #1;
      check("step_idle_pc", pc, i);
      check("step_idle_count", nvalid, i);
      step = 1'b1;
      @(negedge clk);
      #1;
      step = 1'b0;
    end
    repeat (10) @(negedge clk);
    #1;
    check("step_count", nvalid, 3);
    check("step_pc", pc, 8'h03);
    check("step_drain", expq.size(), 0);

    // Reset asserted during FETCH of pc 6 aborts it asynchronously.
    rst_n = 1'b0;
    fill_rom();
    rom[0] = 16'h1234;
    rom[6] = 16'hA5A5;
    jk[0] = 1'b1; tk[0] = 1'b1; gk[0] = 8'h06;
    run_en = 1'b1;
    expq.delete();
    build(1);
    nvalid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_execs(1, 20, "abort_exec_count");
    @(posedge clk);
    #2;
    check("abort_fetch_pc", pc, 8'h06);
    check("abort_fetch_addr", imem_addr, 8'h06);
    rst_n = 1'b0;
    #1;
    check("abort_rst_pc", pc, 8'h00);
    check("abort_rst_addr", imem_addr, 8'h00);
    check("abort_rst_inst", inst, 16'h0000);
    check("abort_rst_valid", inst_valid, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    check("abort_no_exec", nvalid, 1);
    check("abort_drain", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
